ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
Instruction fetch front end that consumes the word-addressed PC stream from the PC logic, issues in-order reads to instruction memory via a valid/ready handshake, and buffers returned words with their PC for decode.
- Decode drives the jump/branch fields (Instr[25:0], sign-extended immediate) back into the PC logic from instr_data.
- A redirect (taken branch or jump) asserts flush, which discards queued and in-flight fetches.
- Closes the PC loop between the PC logic and decode.

Parameters:
- DEPTH, 4: maximum outstanding plus buffered fetches (power of 2, ≥2).
- AW, 32: PC / memory word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_in  in  AW  next fetch word address from the PC logic.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  fetch accepted this cycle.
- mem_req_valid  out  1  read request to instruction memory.
- mem_req_addr  out  AW  request word address (= pc_in).
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  read data valid; responses are in request order.
- mem_rsp_data  in  32  instruction word.
- instr_valid  out  1  head instruction available.
- instr_data  out  32  head instruction word.
- instr_pc  out  AW  word address of head instruction.
- instr_ready  in  1  decode consumes head.
- flush  in  1  redirect; discard everything older.

Behaviour:
- Reset (async, active-high): all pointers, counters and drop count are 0. instr_valid=0, mem_req_valid=0, pc_ready=0, instr_data=0, instr_pc=0.
- Credit: used = pc-FIFO occupancy, i.e. issued and not yet popped, including in-flight. credit = (used < DEPTH).
- mem_req_valid = pc_valid & credit & ~flush.
  - mem_req_addr = pc_in, combinational pass-through.
  - pc_ready = mem_req_valid & mem_req_ready.
- Issue:
  - On pc_ready, pc_in is pushed into the PC FIFO (DEPTH entries).
  - The in-flight counter increments.
- Response:
  - On mem_rsp_valid with drop_cnt = 0, the word is written to the data FIFO (DEPTH entries) and in-flight decrements.
  - With drop_cnt > 0, the word is discarded and both drop_cnt and in-flight decrement.
- Output:
  - instr_valid = (data FIFO count > 0).
  - instr_data = data FIFO head; instr_pc = PC FIFO head. Heads stay aligned because responses are in order.
  - Pop both FIFOs on instr_valid & instr_ready.
- Latency: a response written at edge N gives instr_valid=1 in cycle N+1. Issue-to-output is 1 cycle plus memory latency.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Wrap-around: pointers are log2(DEPTH)+1 bits; full/empty are decided by the MSB comparison.
- Flush (synchronous priority over push and pop):
  - Both FIFOs are emptied at the next edge.
  - drop_cnt <= in-flight count minus any response consumed in the flush cycle.
  - No request is issued during the flush cycle.
  - An instr_ready handshake in the flush cycle is ignored.
  - From the next cycle, new fetches may issue while drops are still pending; the pending drops are older, so ordering stays correct.
- Response with in-flight = 0 is a protocol error: ignored, counters unchanged.
- Reset mid-operation clears all state immediately, independent of clk.

Optional Feature:
- IFQ_BYPASS_EN defined:
  - When the data FIFO is empty, drop_cnt = 0 and mem_rsp_valid=1, instr_valid is asserted in the same cycle with instr_data = mem_rsp_data.
  - If instr_ready=1, the word is not written and the PC FIFO pops; otherwise the word is written as normal.
  - Gives zero-cycle response-to-decode latency.
- IFQ_BYPASS_EN undefined: always the registered 1-cycle path described in Behaviour.

Test Plan:
- Back-to-back fetch:
  - Stimulus: pc_in 0,1,2,3; mem_req_ready=1; 2-cycle memory; instr_ready=1.
  - Required: instr_pc 0,1,2,3 with matching data, one per cycle; no bubble after the first.
- Credit stall:
  - Stimulus: DEPTH=4, instr_ready=0, 6 fetch attempts.
  - Required: exactly 4 accepted; pc_ready=0 after the 4th; one pop re-enables exactly one issue.
- Flush with 2 in flight:
  - Stimulus: flush while 2 requests are in flight and 1 word is queued; then issue pc 0x40.
  - Required: next 2 responses are dropped; first instr_pc=0x40; no stale instr_valid.
- Wrap-around:
  - Stimulus: 20 sequential fetches with random instr_ready and random mem_req_ready.
  - Required: every output (pc, data) pair matches a scoreboard; no loss and no duplicate.
- Async reset:
  - Stimulus: assert reset mid-cycle with 3 queued entries.
  - Required: instr_valid=0 and mem_req_valid=0 immediately; after release, first fetch behaves as from empty.
- Bypass (IFQ_BYPASS_EN):
  - Stimulus: empty queue, response 0x8C020004, instr_ready=1.
  - Required: instr_valid=1 and instr_data=0x8C020004 in the same cycle; FIFO count stays 0.

Source files
------------

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Brief    : In-order instruction fetch queue between the PC logic, instruction
//            memory and decode. Define IFQ_BYPASS_EN for zero-cycle rsp->decode.
// Revision : 1.0
// ============================================================================
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_valid,
    output logic          pc_ready,
    output logic          mem_req_valid,
    output logic [AW-1:0] mem_req_addr,
    input  logic          mem_req_ready,
    input  logic          mem_rsp_valid,
    input  logic [31:0]   mem_rsp_data,
    output logic          instr_valid,
    output logic [31:0]   instr_data,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready,
    input  logic          flush
);

    localparam int c_ptr_w = $clog2(DEPTH);
    // In-flight can reach DEPTH live fetches plus DEPTH pending drops.
    localparam int c_cnt_w = c_ptr_w + 2;
    localparam logic [c_ptr_w:0]   c_ptr_one = 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one = 1;

    logic [AW-1:0]      pc_mem_q [DEPTH];
    logic [AW-1:0]      pc_mem_d [DEPTH];
    logic [31:0]        dt_mem_q [DEPTH];
    logic [31:0]        dt_mem_d [DEPTH];
    logic [c_ptr_w:0]   pc_wr_q, pc_wr_d;
    logic [c_ptr_w:0]   pc_rd_q, pc_rd_d;
    logic [c_ptr_w:0]   dt_wr_q, dt_wr_d;
    logic [c_ptr_w:0]   dt_rd_q, dt_rd_d;
    logic [c_cnt_w-1:0] inflight_q, inflight_d;
    logic [c_cnt_w-1:0] drop_q, drop_d;

    logic w_pc_full;
    logic w_dt_empty;
    logic w_req_valid;
    logic w_issue;
    logic w_rsp_acc;
    logic w_rsp_drop;
    logic w_rsp_keep;
    logic w_bypass;
    logic w_pop;
    logic w_dt_pop;
    logic w_dt_push;

    assign w_pc_full  = (pc_wr_q[c_ptr_w] != pc_rd_q[c_ptr_w]) &&
                        (pc_wr_q[c_ptr_w-1:0] == pc_rd_q[c_ptr_w-1:0]);
    assign w_dt_empty = (dt_wr_q == dt_rd_q);

    // Request side: credit is the PC FIFO not being full; reset also blocks it.
    assign w_req_valid   = pc_valid & ~w_pc_full & ~flush & ~reset;
    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = pc_in;
    assign w_issue       = w_req_valid & mem_req_ready;
    assign pc_ready      = w_issue;

    // A response with nothing in flight is a protocol error and is ignored.
    assign w_rsp_acc  = mem_rsp_valid & (inflight_q != '0);
    assign w_rsp_drop = w_rsp_acc & (drop_q != '0);
    assign w_rsp_keep = w_rsp_acc & (drop_q == '0);

`ifdef IFQ_BYPASS_EN
    assign w_bypass = w_rsp_keep & w_dt_empty & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign instr_valid = ~w_dt_empty | w_bypass;
    assign instr_data  = w_bypass ? mem_rsp_data : dt_mem_q[dt_rd_q[c_ptr_w-1:0]];
    assign instr_pc    = pc_mem_q[pc_rd_q[c_ptr_w-1:0]];

    assign w_pop     = instr_valid & instr_ready & ~flush;
    assign w_dt_pop  = w_pop & ~w_dt_empty;
    assign w_dt_push = w_rsp_keep & ~(w_bypass & instr_ready);

    always_comb begin
        pc_mem_d   = pc_mem_q;
        dt_mem_d   = dt_mem_q;
        pc_wr_d    = pc_wr_q;
        pc_rd_d    = pc_rd_q;
        dt_wr_d    = dt_wr_q;
        dt_rd_d    = dt_rd_q;
        drop_d     = drop_q;
        inflight_d = inflight_q;

        if (w_issue) begin
            inflight_d = inflight_d + c_cnt_one;
        end
        if (w_rsp_acc) begin
            inflight_d = inflight_d - c_cnt_one;
        end

        if (flush) begin
            // Everything still in flight after this edge belongs to the old stream.
            pc_rd_d = pc_wr_q;
            dt_rd_d = dt_wr_q;
            drop_d  = w_rsp_acc ? (inflight_q - c_cnt_one) : inflight_q;
        end else begin
            if (w_issue) begin
                pc_mem_d[pc_wr_q[c_ptr_w-1:0]] = pc_in;
                pc_wr_d = pc_wr_q + c_ptr_one;
            end
            if (w_pop) begin
                pc_rd_d = pc_rd_q + c_ptr_one;
            end
            if (w_dt_push) begin
                dt_mem_d[dt_wr_q[c_ptr_w-1:0]] = mem_rsp_data;
                dt_wr_d = dt_wr_q + c_ptr_one;
            end
            if (w_dt_pop) begin
                dt_rd_d = dt_rd_q + c_ptr_one;
            end
            if (w_rsp_drop) begin
                drop_d = drop_q - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i] <= '0;
                dt_mem_q[i] <= '0;
            end
            pc_wr_q    <= '0;
            pc_rd_q    <= '0;
            dt_wr_q    <= '0;
            dt_rd_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_mem_q   <= pc_mem_d;
            dt_mem_q   <= dt_mem_d;
            pc_wr_q    <= pc_wr_d;
            pc_rd_q    <= pc_rd_d;
            dt_wr_q    <= dt_wr_d;
            dt_rd_q    <= dt_rd_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_queue
// Brief    : Directed self-checking bench for ifetch_queue with an in-order
//            memory model and a PC/data scoreboard.
// Revision : 1.0
// ============================================================================
module tb_ifetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
`ifdef IFQ_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic          pc_valid;
    logic          pc_ready;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [31:0]   mem_rsp_data;
    logic          instr_valid;
    logic [31:0]   instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          flush;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .AW(AW)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .pc_valid     (pc_valid),
        .pc_ready     (pc_ready),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .flush        (flush)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } mreq_t;

    mreq_t         memq[$];
    logic [AW-1:0] expq[$];
    int            cyc;
    int            lat;
    int            n_chk;
    int            n_fail;
    int            n_iss;
    int            n_pop;
    int            first_pop_cyc;
    int            last_pop_cyc;
    logic          last_iss;
    logic          cur_req;
    logic          cur_valid;
    logic [31:0]   cur_data;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        if (a == 32'h400) return 32'h8C02_0004;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_chk++;
        if (obs !== expd) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, expd, cyc);
        end
    endtask

    // One clock cycle: memory drives its response, outputs are sampled 1 ns in,
    // then the bench advances to the next falling edge.
    task automatic cycle();
        mreq_t       h;
        logic [31:0] e;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        #1;
        cur_req   = mem_req_valid;
        cur_valid = instr_valid;
        cur_data  = instr_data;
        last_iss  = pc_ready;
        if (mem_req_valid) check_val("req_addr", mem_req_addr, pc_in);
        if (pc_ready) begin
            n_iss++;
            memq.push_back('{addr: pc_in, due: cyc + lat});
            expq.push_back(pc_in);
        end
        if (mem_rsp_valid) h = memq.pop_front();
        if (instr_valid && instr_ready && !flush) begin
            n_pop++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            check_val("sb_nonempty", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check_val("instr_pc", instr_pc, e);
                check_val("instr_data", instr_data, mem_word(e));
            end
        end
        if (flush) expq.delete();
        @(negedge clk);
        cyc++;
    endtask

    task automatic mark();
        n_pop         = 0;
        first_pop_cyc = -1;
        last_pop_cyc  = -1;
    endtask

    initial begin
        int base;
        int start;
        int stale;

        reset = 1'b1; pc_in = '0; pc_valid = 1'b1; mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; instr_ready = 1'b1; flush = 1'b0;
        cyc = 0; lat = 2; n_chk = 0; n_fail = 0; n_iss = 0; mark();

        // Reset state, with pc_valid held high to show requests stay blocked.
        @(negedge clk);
        #1;
        check_val("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_val("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check_val("rst_pc_ready", 32'(pc_ready), 32'd0);
        check_val("rst_instr_data", instr_data, 32'd0);
        check_val("rst_instr_pc", instr_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0; pc_valid = 1'b0;

        // Back-to-back fetch with 2-cycle memory.
        mark(); start = cyc;
        for (int i = 0; i < 4; i++) begin
            pc_valid = 1'b1; pc_in = 32'(i);
            cycle();
            check_val("b2b_issue", 32'(last_iss), 32'd1);
        end
        pc_valid = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        check_val("b2b_count", 32'(n_pop), 32'd4);
        check_val("b2b_first_lat", 32'(first_pop_cyc - start), 32'(3 - BYP));
        check_val("b2b_span", 32'(last_pop_cyc - first_pop_cyc), 32'd3);

        // Credit stall: only DEPTH fetches fit while decode is stalled.
        instr_ready = 1'b0; base = n_iss;
        for (int i = 0; i < 6; i++) begin
            pc_valid = 1'b1; pc_in = 32'h10 + 32'(n_iss - base);
            cycle();
        end
        check_val("stall_accepted", 32'(n_iss - base), 32'd4);
        check_val("stall_ready_low", 32'(last_iss), 32'd0);
        for (int i = 0; i < 3; i++) cycle();
        check_val("stall_hold", 32'(n_iss - base), 32'd4);
        instr_ready = 1'b1; cycle();
        check_val("stall_pop_cycle_issue", 32'(last_iss), 32'd0);
        instr_ready = 1'b0; cycle();
        check_val("stall_reissue", 32'(last_iss), 32'd1);
        pc_in = 32'h15; cycle();
        check_val("stall_one_only", 32'(last_iss), 32'd0);
        pc_valid = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check_val("stall_drain", 32'(expq.size()), 32'd0);

        // Flush with one word queued and two fetches in flight.
        lat = 4; instr_ready = 1'b0;
        pc_valid = 1'b1; pc_in = 32'h20; cycle();
        pc_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        pc_valid = 1'b1; pc_in = 32'h21; cycle();
        pc_in = 32'h22; cycle();
        pc_in = 32'h40; flush = 1'b1; instr_ready = 1'b1; cycle();
        check_val("flush_queued_valid", 32'(cur_valid), 32'd1);
        check_val("flush_req_valid", 32'(cur_req), 32'd0);
        check_val("flush_no_issue", 32'(last_iss), 32'd0);
        flush = 1'b0; mark(); start = cyc;
        cycle();
        check_val("flush_new_issue", 32'(last_iss), 32'd1);
        pc_valid = 1'b0; stale = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (cur_valid) stale++;
        end
        check_val("flush_stale_valid", 32'(stale), 32'd0);
        for (int i = 0; i < 4; i++) cycle();
        check_val("flush_pop_count", 32'(n_pop), 32'd1);
        check_val("flush_first_lat", 32'(first_pop_cyc - start), 32'(5 - BYP));

        // Wrap-around: 20 fetches with random backpressure on both sides.
        lat = 2; mark(); base = n_iss;
        for (int k = 0; k < 400 && (n_iss - base) < 20; k++) begin
            pc_valid      = 1'b1;
            pc_in         = 32'h100 + 32'(n_iss - base);
            mem_req_ready = 1'($urandom_range(0, 1));
            instr_ready   = 1'($urandom_range(0, 1));
            cycle();
        end
        check_val("wrap_issued", 32'(n_iss - base), 32'd20);
        pc_valid = 1'b0; mem_req_ready = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 40 && expq.size() > 0; k++) cycle();
        check_val("wrap_popped", 32'(n_pop), 32'd20);
        check_val("wrap_sb_empty", 32'(expq.size()), 32'd0);

        // Asynchronous reset with three words queued.
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_valid = 1'b1; pc_in = 32'h200 + 32'(i);
            cycle();
        end
        pc_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        pc_valid = 1'b1; pc_in = 32'h203; mem_rsp_valid = 1'b0;
        #1;
        check_val("pre_rst_valid", 32'(instr_valid), 32'd1);
        check_val("pre_rst_pc", instr_pc, 32'h200);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_instr_valid", 32'(instr_valid), 32'd0);
        check_val("arst_req_valid", 32'(mem_req_valid), 32'd0);
        check_val("arst_instr_pc", instr_pc, 32'd0);
        @(negedge clk);
        cyc++;
        reset = 1'b0; pc_valid = 1'b0;
        memq.delete(); expq.delete();
        instr_ready = 1'b1; mark(); start = cyc;
        pc_valid = 1'b1; pc_in = 32'h300; cycle();
        check_val("post_rst_issue", 32'(last_iss), 32'd1);
        pc_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check_val("post_rst_pops", 32'(n_pop), 32'd1);
        check_val("post_rst_lat", 32'(first_pop_cyc - start), 32'(3 - BYP));

        // Response-to-decode latency on an empty queue.
        mark();
        pc_valid = 1'b1; pc_in = 32'h400; cycle();
        pc_valid = 1'b0; cycle();
        cycle();
`ifdef IFQ_BYPASS_EN
        check_val("byp_same_cycle_valid", 32'(cur_valid), 32'd1);
        check_val("byp_same_cycle_data", cur_data, 32'h8C02_0004);
        cycle();
        check_val("byp_not_stored", 32'(cur_valid), 32'd0);
`else
        check_val("reg_rsp_cycle_valid", 32'(cur_valid), 32'd0);
        cycle();
        check_val("reg_next_valid", 32'(cur_valid), 32'd1);
        check_val("reg_next_data", cur_data, 32'h8C02_0004);
`endif
        cycle();
        check_val("lat_pops", 32'(n_pop), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
